// File: rtl/psx_pkg.sv
// Shared types and constants for the emulated PlayStation digital pad.
package psx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    ACK_WAIT,
    ACK_PULSE,
    IGNORE
  } psx_state_t;

  localparam logic [7:0] CMD_START  = 8'h01;
  localparam logic [7:0] CMD_POLL   = 8'h42;
  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] RPL_IDLE   = 8'hFF;
  localparam logic [7:0] RPL_PAD_ID = 8'h41;
  localparam logic [7:0] RPL_READY  = 8'h5A;

  localparam int NUM_POLL_BYTES = 5;

  function automatic logic [7:0] tx_for_byte(input logic [2:0] idx,
                                             input logic [7:0] pad_id,
                                             input logic [15:0] btn);
    case (idx)
      3'd0:    return RPL_IDLE;
      3'd1:    return pad_id;
      3'd2:    return RPL_READY;
      3'd3:    return btn[7:0];
      default: return btn[15:8];
    endcase
  endfunction

endpackage

// File: rtl/psx_sync_edge.sv
// Two-flop synchroniser with registered history for single-cycle edge pulses.
module psx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, s3;

  // Link lines idle high, so every stage resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/psx_pad_responder.sv
// Slave end of the PSX pad link: answers a digital-pad poll with ID and buttons.
// state     | meaning
// IDLE      | waiting for att to fall
// SHIFT     | shifting a byte on psx_clk edges
// ACK_WAIT  | byte done, delaying before ack
// ACK_PULSE | holding ack low
// IGNORE    | frame rejected or finished, wait for att to rise
module psx_pad_responder
  import psx_pkg::*;
#(
  parameter int         ACK_DELAY = 16,
  parameter int         ACK_WIDTH = 8,
  parameter logic [7:0] PAD_ID    = 8'h41
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psx_clk,
  input  logic        cmd,
  input  logic        att,
  input  logic [15:0] buttons,
  output logic        data,
  output logic        ack,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        poll_done
);

  localparam logic [7:0] DELAY_LOAD = 8'(ACK_DELAY - 1);
  localparam logic [7:0] WIDTH_LOAD = 8'(ACK_WIDTH - 1);
  localparam logic [2:0] LAST_BYTE  = 3'(NUM_POLL_BYTES - 1);

  logic clk_rise, clk_fall, att_rise, att_fall, cmd_lvl;
  logic clk_lvl_unused, att_lvl_unused, cmd_rise_unused, cmd_fall_unused;

  psx_sync_edge u_sync_clk (.clk(clk), .rst(rst), .din(psx_clk),
                            .level(clk_lvl_unused), .rise(clk_rise), .fall(clk_fall));
  psx_sync_edge u_sync_att (.clk(clk), .rst(rst), .din(att),
                            .level(att_lvl_unused), .rise(att_rise), .fall(att_fall));
  psx_sync_edge u_sync_cmd (.clk(clk), .rst(rst), .din(cmd),
                            .level(cmd_lvl), .rise(cmd_rise_unused), .fall(cmd_fall_unused));

  psx_state_t  state_q, state_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [15:0] btn_q, btn_d;
  logic        data_d, ack_d, rx_valid_d, poll_done_d;
  logic [7:0]  rx_byte_d, rx_full;

  assign rx_full = {cmd_lvl, rx_shift_q[6:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      cnt_q      <= '0;
      tx_q       <= RPL_IDLE;
      rx_shift_q <= '0;
      btn_q      <= '1;
      data       <= 1'b1;
      ack        <= 1'b1;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      poll_done  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_shift_q <= rx_shift_d;
      btn_q      <= btn_d;
      data       <= data_d;
      ack        <= ack_d;
      rx_byte    <= rx_byte_d;
      rx_valid   <= rx_valid_d;
      poll_done  <= poll_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    tx_d        = tx_q;
    rx_shift_d  = rx_shift_q;
    btn_d       = btn_q;
    data_d      = data;
    ack_d       = ack;
    rx_byte_d   = rx_byte;
    rx_valid_d  = 1'b0;
    poll_done_d = 1'b0;

    if (att_rise) begin
      state_d    = IDLE;
      data_d     = 1'b1;
      ack_d      = 1'b1;
      byte_idx_d = '0;
      bit_idx_d  = '0;
      cnt_d      = '0;
    end else begin
      case (state_q)
        IDLE: begin
          data_d = 1'b1;
          ack_d  = 1'b1;
          if (att_fall) begin
            btn_d      = buttons;
            tx_d       = RPL_IDLE;
            byte_idx_d = '0;
            bit_idx_d  = '0;
            state_d    = SHIFT;
          end
        end
        SHIFT: begin
          if (clk_fall) begin
            data_d = tx_q[bit_idx_q];
          end else if (clk_rise) begin
            rx_shift_d[bit_idx_q] = cmd_lvl;
            bit_idx_d             = bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              rx_byte_d  = rx_full;
              rx_valid_d = 1'b1;
              data_d     = 1'b1;
              if ((byte_idx_q == 3'd0 && rx_full != CMD_START) ||
                  (byte_idx_q == 3'd1 && rx_full != CMD_POLL)) begin
                state_d = IGNORE;
              end else if (byte_idx_q == LAST_BYTE) begin
                poll_done_d = 1'b1;
                state_d     = IGNORE;
              end else begin
                tx_d    = tx_for_byte(byte_idx_q + 3'd1, PAD_ID, btn_q);
                cnt_d   = DELAY_LOAD;
                state_d = ACK_WAIT;
              end
            end
          end
        end
        ACK_WAIT, ACK_PULSE: begin
          // A master that does not wait for ack starts the next byte early.
          if (clk_fall) begin
            ack_d      = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
            bit_idx_d  = '0;
            data_d     = tx_q[0];
            state_d    = SHIFT;
          end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (state_q == ACK_WAIT) begin
            ack_d   = 1'b0;
            cnt_d   = WIDTH_LOAD;
            state_d = ACK_PULSE;
          end else begin
            ack_d      = 1'b1;
            byte_idx_d = byte_idx_q + 3'd1;
            bit_idx_d  = '0;
            state_d    = SHIFT;
          end
        end
        IGNORE: begin
          data_d = 1'b1;
          ack_d  = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/psx_pad_responder.md
Name: psx_pad_responder

Overview:
- Emulated digital PlayStation controller: the slave end of the PSX pad link.
- Consumes the console master's psx_clk/cmd/att lines and produces data/ack.
- Answers a standard digital-pad poll (0x01, 0x42, three reads) with ID 0x41, 0x5A and a 16-bit button snapshot. Used to close the loop with the console-side master.
- Oversamples the link on the system clock; no logic is clocked by psx_clk.

Parameters:
- ACK_DELAY, 16: clk cycles from byte completion (8th psx_clk rising edge) to ack assertion.
- ACK_WIDTH, 8: clk cycles ack is held low.
- PAD_ID, 8'h41: reply byte for byte 1 (digital pad).

Ports:
- clk  in  1  system clock; must be at least 4x the master's clock.
- rst  in  1  synchronous, active-high reset.
- psx_clk  in  1  link clock from the master; idle high.
- cmd  in  1  master command bit, LSB first, valid at psx_clk rising edge.
- att  in  1  attention, active low; frames one poll.
- buttons  in  16  button state, active low; bit0 = SELECT … bit15 = SQUARE (standard order).
- data  out  1  reply bit to master; idle high.
- ack  out  1  acknowledge, active low; idle high.
- rx_byte  out  8  last command byte received.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- poll_done  out  1  one-cycle pulse after a complete valid 5-byte poll.

Behaviour:
- Synchronisation:
  - psx_clk, cmd and att each pass through a 2-flop synchroniser; sync flops reset to 1.
  - Edges are detected on the synchronised signals, so input-to-action latency is 3 clk.
- Reset values: data=1, ack=1, rx_byte=0, rx_valid=0, poll_done=0, state=IDLE, byte_idx=0, bit_idx=0.
- States:
  - IDLE: data=1, ack=1. On att falling edge: snapshot buttons into btn_q, load tx_byte=8'hFF, byte_idx=0, bit_idx=0, go to SHIFT.
  - SHIFT:
    - On psx_clk falling edge: data <= tx_byte[bit_idx].
    - On psx_clk rising edge: rx_shift[bit_idx] <= cmd, and bit_idx increments.
    - After the 8th rising edge: rx_byte <= full byte, rx_valid pulses, data <= 1, then the header check below runs.
  - Header check after each byte:
    - byte 0 must be 8'h01 and byte 1 must be 8'h42. On a mismatch go to IGNORE, with no ack.
    - byte_idx 0–3: load the next tx_byte, go to ACK_WAIT.
    - byte_idx 4: poll_done pulses, go to IGNORE (no ack after the last byte).
  - tx_byte sequence by byte_idx:
    - 0 → 8'hFF
    - 1 → PAD_ID
    - 2 → 8'h5A
    - 3 → btn_q[7:0]
    - 4 → btn_q[15:8]
  - ACK_WAIT: count ACK_DELAY cycles, then ack <= 0 and go to ACK_PULSE.
  - ACK_PULSE: count ACK_WIDTH cycles, then ack <= 1, byte_idx++, bit_idx=0, go to SHIFT.
  - IGNORE: data=1, ack=1. Ignores psx_clk until att rises.
- Boundaries:
  - att rising edge in any state aborts immediately: data=1, ack=1, counters cleared, go to IDLE. att has priority over a simultaneous psx_clk edge.
  - psx_clk falling edge during ACK_WAIT or ACK_PULSE (master not waiting for ack):
    - ack <= 1, advance byte_idx, enter SHIFT.
    - Drive bit 0 of the new tx_byte in the same cycle.
  - buttons changing mid-poll does not affect the reply; only the att-fall snapshot is used.
  - Counters are sized for parameter values up to 255 and do not wrap within a poll.
  - rst asserted mid-poll returns all outputs to reset values on the next clk edge.

Decomposition:
- Package psx_pkg holds:
  - the state enum (IDLE, SHIFT, ACK_WAIT, ACK_PULSE, IGNORE);
  - constants CMD_START=8'h01, CMD_POLL=8'h42, CMD_NOP=8'h00, RPL_IDLE=8'hFF, RPL_PAD_ID=8'h41, RPL_READY=8'h5A;
  - NUM_POLL_BYTES=5.
- One sub-module, psx_sync_edge: 2-flop synchroniser plus rise/fall pulse outputs, reset value 1. Instantiated three times.

Test Plan:
1. Standard poll; buttons=16'hFFFE, cmd bytes 01,42,00,00,00.
   - data bytes = FF,41,5A,FE,FF.
   - rx_byte sequence = 01,42,00,00,00.
   - 4 ack pulses, each ACK_WIDTH wide and ACK_DELAY after byte end.
   - poll_done pulses once; no 5th ack.
2. Byte 0 = 8'h03:
   - rx_valid pulses with rx_byte=03.
   - No ack; data stays 1 for the rest of the frame.
   - No poll_done.
3. att raised after 4 bits of byte 2:
   - IDLE within 3 clk; data=1, ack=1.
   - Next poll returns FF,41,5A normally.
4. buttons change from 16'hFFFF to 16'h0000 after att falls:
   - Bytes 3/4 = FF,FF.
   - Next poll returns 00,00.
5. Master clocks byte 2 starting 2 cycles into ACK_PULSE:
   - ack returns to 1 immediately.
   - Byte 2 still reads 5A.
6. rst pulsed during byte 3:
   - All outputs at reset values.
   - No poll_done until a full new poll completes.
